rom_prefetch_buffer: RTL and testbench
======================================

Name: rom_prefetch_buffer

Overview:
Sliding-window prefetch buffer between the atari2600 cartridge ROM bus and the qspi_flash_controller. It streams sequential bytes from flash into a small circular buffer and serves CPU ROM reads that hit the window. On a miss it stops the current stream, restarts at the requested address, and stalls the system through wait_for_memory until the byte arrives. It replaces the ad-hoc two-address cache in the top level.

Parameters:
DEPTH, 8, buffer entries; power of two, range 4..32.
KEEP_BEHIND, 2, bytes kept below the last hit address so short backward branches still hit; must be < DEPTH.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
bank  in  8  ROM configuration byte captured during reset
rom_read  in  1  valid ROM address on the bus this cycle
rom_cycle  in  1  core samples rom_data this cycle
rom_address  in  12  cartridge address
rom_data  out  8  registered ROM byte
wait_for_memory  out  1  freeze request to the core
spi_addr  out  24  flash start address: {bank[7:5],1'b1,bank[3:0],4'b0000,fill_addr}
spi_start_read  out  1  single-cycle start pulse
spi_stop_read  out  1  single-cycle stop pulse
spi_stall_read  out  1  hold the controller; asserted while the buffer is full
spi_data  in  8  byte from the controller
spi_data_ready  in  1  byte valid; a byte is accepted on the 0->1 edge only
spi_busy  in  1  controller transaction active
hit_count  out  16  see Optional Feature
miss_count  out  16  see Optional Feature

Behaviour:
- Window state: base (12b), count (0..DEPTH), fill_addr = base+count (mod 4096). Entry for address a is buf[a mod DEPTH].
- Hit: rom_read && (rom_address - base) mod 4096 < count.
- Hit latency: rom_data <= buf entry at the next edge; data_valid <= 1.
- Hit slide: if offset = rom_address - base > KEEP_BEHIND, then base += offset - KEEP_BEHIND and count -= the same amount.
- Miss: when rom_read && !hit && !(pending request for the same address):
  - data_valid <= 0, count <= 0, base <= rom_address, miss_pending <= 1.
  - If the FSM is in STREAM, pulse spi_stop_read.
- wait_for_memory = rom_cycle && !data_valid. The core holds rom_address stable while frozen.
- Byte arrival while miss_pending: when the byte for base arrives, rom_data <= spi_data, data_valid <= 1, miss_pending <= 0, in the same edge that writes the buffer.
- FSM:
  - IDLE: if (miss_pending || count < DEPTH) && !spi_busy && fill_addr != 0 (or miss_pending is set), pulse spi_start_read with spi_addr from fill_addr; go to STREAM.
  - STREAM, accepted byte: write buf, count += 1.
  - STREAM, fill_addr was 0xFFF: after capture, pulse spi_stop_read and go to DONE. The stream never crosses the 4K boundary.
  - STREAM, miss: pulse spi_stop_read and go to IDLE. Bytes arriving in the cycle of the stop pulse are discarded.
  - DONE: holds until a miss, then goes to IDLE.
  - spi_stall_read = (count == DEPTH) && state == STREAM. When a slide frees space, stall drops the next cycle.
- Simultaneous events:
  - Accepted byte in the same cycle as a hit slide: both are applied; count = count + 1 - slide.
  - Miss in the same cycle as an accepted byte: the byte is dropped.
- Reset: state IDLE, base 0, count 0, data_valid 0, miss_pending 0, rom_data 0x00, all spi strobes 0, counters 0. Reset mid-stream abandons the transaction without a stop pulse; the controller is reset by the same rst_n.

Optional Feature:
ROM_PREFETCH_STATS_EN
- Defined: hit_count and miss_count increment once per rom_read cycle that first classifies the address as hit or miss (a repeated classification while frozen is not counted). Both saturate at 0xFFFF and clear on reset.
- Undefined: both ports are driven 16'h0000 and no counter flops exist.

Test Plan:
- Cold start, bank=0x10, rom_read 0xFFC: start pulse with spi_addr=0x100FFC -> wait_for_memory high until 0xFFC arrives; rom_data=byte@0xFFC one cycle later.
- Sequential reads 0x000..0x00F with the model delivering 1 byte every 8 clocks, DEPTH=8: every read after the first hits once filled; stall asserted when count=8; no restart pulses.
- Jump from 0x010 to 0x800 mid-stream: one spi_stop_read pulse, then spi_start_read at 0x800 once busy=0; wait_for_memory until data; miss_count +1.
- Backward branch: read 0x020, then 0x01F (KEEP_BEHIND=2) -> hit, no wait; then read 0x01C -> miss and restart.
- Fill reaching 0xFFF: after capture, a stop pulse and no further bytes accepted; read 0x000 -> miss and restart at 0x000.
- rst_n low for 1 cycle mid-stream -> all outputs at reset values next cycle; next rom_read issues a fresh start pulse.

Source files
------------

// File: rtl/rom_prefetch_buffer.sv
// rom_prefetch_buffer: sliding-window prefetch buffer between the cartridge ROM bus and the
// QSPI flash controller. Sequential flash bytes stream into a small circular buffer, and ROM
// reads that fall inside the window are served from it. A read outside the window restarts
// the stream at the requested address and freezes the core until that byte arrives.
//
// Optional build macro: ROM_PREFETCH_STATS_EN adds saturating hit/miss counters on
// hit_count/miss_count. Without it both ports are tied to zero.
module rom_prefetch_buffer #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned KEEP_BEHIND = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  bank,
  input  logic        rom_read,
  input  logic        rom_cycle,
  input  logic [11:0] rom_address,
  output logic [7:0]  rom_data,
  output logic        wait_for_memory,
  output logic [23:0] spi_addr,
  output logic        spi_start_read,
  output logic        spi_stop_read,
  output logic        spi_stall_read,
  input  logic [7:0]  spi_data,
  input  logic        spi_data_ready,
  input  logic        spi_busy,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = IdxW + 1;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [11:0]     base_q, base_d;
  logic [CntW-1:0] count_q, count_d;
  logic            data_valid_q, data_valid_d;
  logic            miss_pending_q, miss_pending_d;
  logic [7:0]      rom_data_q, rom_data_d;
  logic            ready_prev_q;
  logic [7:0]      bank_q;
  logic [7:0]      buf_q [DEPTH];

  logic [11:0]     fill_addr;
  logic [11:0]     offset;
  logic            hit_now;
  logic            same_pending;
  logic            miss_now;
  logic [CntW-1:0] slide_amt;
  logic            room;
  logic            byte_edge;
  logic            accept;
  logic            fill_last;
  logic            start_pulse;
  logic            stop_pulse;

  // Bit 4 of the bank byte does not take part in the flash address.
  logic unused_bank;
  assign unused_bank = bank[4];

  assign fill_addr    = base_q + 12'(count_q);
  assign offset       = rom_address - base_q;
  assign hit_now      = rom_read && (offset < 12'(count_q));
  // While frozen the core keeps presenting the address we are already fetching.
  assign same_pending = miss_pending_q && (rom_address == base_q);
  assign miss_now     = rom_read && !hit_now && !same_pending;
  assign byte_edge    = spi_data_ready && !ready_prev_q;
  assign fill_last    = (fill_addr == 12'hFFF);

  // Window slide on a hit far enough ahead of base; keeps KEEP_BEHIND bytes below the hit.
  always_comb begin
    slide_amt = '0;
    if (hit_now && (offset > 12'(KEEP_BEHIND))) begin
      slide_amt = CntW'(offset - 12'(KEEP_BEHIND));
    end
  end

  // A full buffer can still take a byte when a slide frees an entry in the same cycle.
  assign room   = (count_q < CntW'(DEPTH)) || (slide_amt != '0);
  // Bytes coinciding with a miss belong to the abandoned stream and are dropped.
  assign accept = (state_q == StStream) && byte_edge && !miss_now && room;

  // Stream control FSM: next state and start/stop strobes.
  always_comb begin
    state_d     = state_q;
    start_pulse = 1'b0;
    stop_pulse  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Hold off in the miss cycle itself: base/count only settle at the next edge.
        if (!miss_now && !spi_busy &&
            (miss_pending_q || ((count_q < CntW'(DEPTH)) && (fill_addr != 12'h000)))) begin
          start_pulse = 1'b1;
          state_d     = StStream;
        end
      end
      StStream: begin
        if (miss_now) begin
          stop_pulse = 1'b1;
          state_d    = StIdle;
        end else if (accept && fill_last) begin
          // Never stream across the 4K boundary.
          stop_pulse = 1'b1;
          state_d    = StDone;
        end
      end
      StDone: begin
        if (miss_now) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Window, read data and miss bookkeeping next-state.
  always_comb begin
    base_d         = base_q;
    count_d        = count_q;
    data_valid_d   = data_valid_q;
    miss_pending_d = miss_pending_q;
    rom_data_d     = rom_data_q;
    if (miss_now) begin
      data_valid_d   = 1'b0;
      count_d        = '0;
      base_d         = rom_address;
      miss_pending_d = 1'b1;
    end else begin
      if (hit_now) begin
        rom_data_d   = buf_q[rom_address[IdxW-1:0]];
        data_valid_d = 1'b1;
        base_d       = base_q + 12'(slide_amt);
      end
      count_d = count_q + CntW'(accept) - slide_amt;
      // First byte after a restart is the one the frozen core is waiting for.
      if (accept && miss_pending_q && (count_q == '0)) begin
        rom_data_d     = spi_data;
        data_valid_d   = 1'b1;
        miss_pending_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      base_q         <= '0;
      count_q        <= '0;
      data_valid_q   <= 1'b0;
      miss_pending_q <= 1'b0;
      rom_data_q     <= 8'h00;
      ready_prev_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      count_q        <= count_d;
      data_valid_q   <= data_valid_d;
      miss_pending_q <= miss_pending_d;
      rom_data_q     <= rom_data_d;
      ready_prev_q   <= spi_data_ready;
    end
  end

  // Bank configuration is only sampled while reset is held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_q <= bank;
    end
  end

  // Circular buffer storage; entry for address a lives at a mod DEPTH.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_q[fill_addr[IdxW-1:0]] <= spi_data;
    end
  end

`ifdef ROM_PREFETCH_STATS_EN
  logic        prev_read_q;
  logic [11:0] prev_addr_q;
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;
  logic        first_class;

  // Only the first cycle of a given read is classified; frozen repeats are ignored.
  assign first_class = rom_read && !(prev_read_q && (rom_address == prev_addr_q));

  // Saturating hit/miss statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_read_q <= 1'b0;
      prev_addr_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      prev_read_q <= rom_read;
      prev_addr_q <= rom_address;
      if (first_class && hit_now && (hit_cnt_q != 16'hFFFF)) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if (first_class && miss_now && (miss_cnt_q != 16'hFFFF)) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = 16'h0000;
  assign miss_count = 16'h0000;
`endif

  assign rom_data        = rom_data_q;
  assign wait_for_memory = rom_cycle && !data_valid_q;
  assign spi_addr        = {bank_q[7:5], 1'b1, bank_q[3:0], 4'b0000, fill_addr};
  // Strobes are quiet while reset is held so a reset never emits a stop.
  assign spi_start_read  = start_pulse && rst_n;
  assign spi_stop_read   = stop_pulse && rst_n;
  assign spi_stall_read  = (state_q == StStream) && (count_q == CntW'(DEPTH));

endmodule

// File: tb/tb_rom_prefetch_buffer.sv
// Testbench for rom_prefetch_buffer: a small flash controller model feeds one byte every
// BYTE_GAP clocks; a table of ROM reads plus hand sequences cover restart, jump, backward
// branch, 4K end-of-stream and mid-stream reset.
module tb_rom_prefetch_buffer;

  localparam int unsigned DEPTH       = 8;
  localparam int unsigned KEEP_BEHIND = 2;
  localparam int          BYTE_GAP    = 8;

  logic        clk;
  logic        rst_n;
  logic [7:0]  bank;
  logic        rom_read;
  logic        rom_cycle;
  logic [11:0] rom_address;
  logic [7:0]  rom_data;
  logic        wait_for_memory;
  logic [23:0] spi_addr;
  logic        spi_start_read;
  logic        spi_stop_read;
  logic        spi_stall_read;
  logic [7:0]  spi_data;
  logic        spi_data_ready;
  logic        spi_busy;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  rom_prefetch_buffer #(
    .DEPTH      (DEPTH),
    .KEEP_BEHIND(KEEP_BEHIND)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bank           (bank),
    .rom_read       (rom_read),
    .rom_cycle      (rom_cycle),
    .rom_address    (rom_address),
    .rom_data       (rom_data),
    .wait_for_memory(wait_for_memory),
    .spi_addr       (spi_addr),
    .spi_start_read (spi_start_read),
    .spi_stop_read  (spi_stop_read),
    .spi_stall_read (spi_stall_read),
    .spi_data       (spi_data),
    .spi_data_ready (spi_data_ready),
    .spi_busy       (spi_busy),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  // Written only by the flash model.
  int          n_start = 0;
  int          n_stop = 0;
  int          n_stall_cycles = 0;
  int          n_start_busy = 0;
  logic [23:0] last_start_addr = '0;

  function automatic logic [7:0] flash_byte(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Flash controller model: samples strobes at negedge, updates its outputs after posedge.
  int          m_timer;
  int          m_tail;
  logic        m_active;
  logic [11:0] m_addr;
  logic        nxt_ready;
  logic        nxt_busy;
  logic [7:0]  nxt_data;

  initial begin : flash_model
    spi_data       = 8'h00;
    spi_data_ready = 1'b0;
    spi_busy       = 1'b0;
    m_timer        = 0;
    m_tail         = 0;
    m_active       = 1'b0;
    m_addr         = '0;
    forever begin
      @(negedge clk);
      nxt_ready = 1'b0;
      nxt_busy  = spi_busy;
      nxt_data  = spi_data;
      if (!rst_n) begin
        m_active = 1'b0;
        m_tail   = 0;
        nxt_busy = 1'b0;
      end else if (spi_stop_read) begin
        n_stop++;
        m_active = 1'b0;
        m_tail   = 2;
      end else if (spi_start_read) begin
        n_start++;
        if (spi_busy) n_start_busy++;
        last_start_addr = spi_addr;
        m_active = 1'b1;
        nxt_busy = 1'b1;
        m_addr   = spi_addr[11:0];
        m_timer  = BYTE_GAP;
      end else begin
        if (m_tail > 0) begin
          m_tail--;
          if (m_tail == 0) nxt_busy = 1'b0;
        end
        if (m_active) begin
          if (m_timer > 1) begin
            m_timer--;
          end else if (!spi_stall_read) begin
            nxt_ready = 1'b1;
            nxt_data  = flash_byte(m_addr);
            m_addr    = m_addr + 12'd1;
            m_timer   = BYTE_GAP;
          end
        end
      end
      if (spi_stall_read) n_stall_cycles++;
      @(posedge clk);
      #1;
      spi_data_ready = nxt_ready;
      spi_busy       = nxt_busy;
      spi_data       = nxt_data;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached before finish");
    $fatal(1, "testbench timeout");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One ROM access: address cycle, then rom_cycle until wait_for_memory drops.
  task automatic do_read(input logic [11:0] a, output logic waited, output logic [7:0] data,
                         output logic stall_before, output logic stall_after);
    rom_address = a;
    rom_read    = 1'b1;
    rom_cycle   = 1'b0;
    @(negedge clk);
    stall_before = spi_stall_read;
    @(posedge clk);
    #1;
    rom_cycle = 1'b1;
    @(negedge clk);
    stall_after = spi_stall_read;
    waited = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (!wait_for_memory) break;
      waited = 1'b1;
      @(negedge clk);
    end
    if (wait_for_memory) begin
      checks++;
      failures++;
      $display("FAIL read_timeout_%03h: wait_for_memory=1, expected 0", a);
    end
    data = rom_data;
    @(posedge clk);
    #1;
    rom_read  = 1'b0;
    rom_cycle = 1'b0;
  endtask

  task automatic check_stats(input string tag);
`ifdef ROM_PREFETCH_STATS_EN
    check({tag, "_hit_count"}, 32'(hit_count), 32'(exp_hits));
    check({tag, "_miss_count"}, 32'(miss_count), 32'(exp_misses));
`else
    check({tag, "_hit_count"}, 32'(hit_count), 32'h0);
    check({tag, "_miss_count"}, 32'(miss_count), 32'h0);
    $display("note %s: stats disabled, model hits=%0d misses=%0d", tag, exp_hits, exp_misses);
`endif
  endtask

  // Checked read with stats bookkeeping.
  task automatic read_expect(input logic [11:0] a, input logic exp_wait);
    logic w;
    logic [7:0] d;
    logic sb;
    logic sa;
    do_read(a, w, d, sb, sa);
    check($sformatf("rd_%03h_wait", a), 32'(w), 32'(exp_wait));
    check($sformatf("rd_%03h_data", a), 32'(d), 32'(flash_byte(a)));
    if (exp_wait) exp_misses++;
    else exp_hits++;
  endtask

  typedef struct {
    logic [11:0] addr;
    logic        exp_wait;
    int          pre_idle;
    logic        chk_stall;
    logic        stall_before;
    logic        stall_after;
  } vec_t;

  vec_t vecs[$];

  initial begin : main
    logic        w;
    logic [7:0]  d;
    logic        sb;
    logic        sa;
    int          base_start;
    int          base_stop;
    int          base_stall;

    // Window tail at the 4K end, restart at 0x000, then a sequential run that slides.
    vecs.push_back('{12'hFFD, 1'b0, 0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{12'hFFE, 1'b0, 0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{12'hFFF, 1'b0, 0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{12'h000, 1'b1, 0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{12'h001, 1'b0, 100, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{12'h002, 1'b0, 10, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{12'h003, 1'b0, 10, 1'b1, 1'b1, 1'b0});
    for (int i = 4; i < 16; i++) begin
      vecs.push_back('{12'(i), 1'b0, 10, 1'b0, 1'b0, 1'b0});
    end

    rom_read    = 1'b0;
    rom_cycle   = 1'b0;
    rom_address = '0;
    bank        = 8'h10;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bank  = 8'h00;

    // Reset state.
    @(negedge clk);
    check("reset_rom_data", 32'(rom_data), 32'h00);
    check("reset_wait", 32'(wait_for_memory), 32'h0);
    check("reset_start", 32'(spi_start_read), 32'h0);
    check("reset_stop", 32'(spi_stop_read), 32'h0);
    check("reset_stall", 32'(spi_stall_read), 32'h0);
    check_stats("reset");
    @(posedge clk);
    #1;
    rom_cycle = 1'b1;
    @(negedge clk);
    check("reset_data_invalid_wait", 32'(wait_for_memory), 32'h1);
    @(posedge clk);
    #1;
    rom_cycle = 1'b0;
    idle(5);
    check("reset_no_spontaneous_start", 32'(n_start), 32'h0);

    // Cold start at 0xFFC with the bank captured during reset.
    do_read(12'hFFC, w, d, sb, sa);
    exp_misses++;
    check("cold_wait", 32'(w), 32'h1);
    check("cold_data", 32'(d), 32'(flash_byte(12'hFFC)));
    check("cold_starts", 32'(n_start), 32'd1);
    check("cold_spi_addr", 32'(last_start_addr), 32'h100FFC);
    idle(60);
    check("fff_stop_pulse", 32'(n_stop), 32'd1);
    check("fff_no_restart", 32'(n_start), 32'd1);
    check("fff_no_stall", 32'(n_stall_cycles), 32'd0);

    foreach (vecs[i]) begin
      idle(vecs[i].pre_idle);
      do_read(vecs[i].addr, w, d, sb, sa);
      check($sformatf("vec%0d_%03h_wait", i, vecs[i].addr), 32'(w), 32'(vecs[i].exp_wait));
      check($sformatf("vec%0d_%03h_data", i, vecs[i].addr), 32'(d),
            32'(flash_byte(vecs[i].addr)));
      if (vecs[i].chk_stall) begin
        check($sformatf("vec%0d_stall_before", i), 32'(sb), 32'(vecs[i].stall_before));
        check($sformatf("vec%0d_stall_after", i), 32'(sa), 32'(vecs[i].stall_after));
      end
      if (vecs[i].exp_wait) exp_misses++;
      else exp_hits++;
    end
    check("seq_starts", 32'(n_start), 32'd2);
    check("seq_restart_addr", 32'(last_start_addr), 32'h100000);
    check("seq_stops", 32'(n_stop), 32'd1);
    check("seq_stall_seen", 32'(n_stall_cycles != 0), 32'h1);
    check_stats("seq");

    // Jump mid-stream: one stop, restart once the controller is idle.
    read_expect(12'h800, 1'b1);
    check("jump_stops", 32'(n_stop), 32'd2);
    check("jump_starts", 32'(n_start), 32'd3);
    check("jump_spi_addr", 32'(last_start_addr), 32'h100800);
    check_stats("jump");

    // Backward branch within KEEP_BEHIND hits; further back misses.
    idle(100);
    read_expect(12'h804, 1'b0);
    read_expect(12'h803, 1'b0);
    read_expect(12'h801, 1'b1);
    check("back_starts", 32'(n_start), 32'd4);
    check("back_spi_addr", 32'(last_start_addr), 32'h100801);
    check("back_stops", 32'(n_stop), 32'd3);
    check_stats("back");

    // One-cycle reset mid-stream with a new bank value.
    idle(20);
    base_stop  = n_stop;
    base_start = n_start;
    rst_n = 1'b0;
    bank  = 8'hA5;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bank  = 8'h00;
    exp_hits   = 0;
    exp_misses = 0;
    @(negedge clk);
    base_stall = n_stall_cycles;
    check("rst2_rom_data", 32'(rom_data), 32'h00);
    check("rst2_stall", 32'(spi_stall_read), 32'h0);
    check("rst2_start", 32'(spi_start_read), 32'h0);
    check("rst2_stop", 32'(spi_stop_read), 32'h0);
    check_stats("rst2");
    idle(5);
    check("rst2_no_stop_pulse", 32'(n_stop), 32'(base_stop));
    check("rst2_no_auto_start", 32'(n_start), 32'(base_start));
    check("rst2_no_stall", 32'(n_stall_cycles), 32'(base_stall));
    read_expect(12'h123, 1'b1);
    check("rst2_fresh_start", 32'(n_start), 32'(base_start + 1));
    check("rst2_spi_addr", 32'(last_start_addr), 32'hB50123);
    check_stats("final");
    check("start_while_busy", 32'(n_start_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
